ram_dual_be: RTL and testbench

Dual-port, byte-masked, clock-enabled synchronous RAM, the parametrised successor of the team's single-port simulation RAM. It serves two independent channels, A and B, each with its own address, write mask and read enable. Read latency is selectable and the same-port read-during-write mode is selectable. Memory is cleared by an internal initialisation sequencer rather than a reset-time array clear. It sits between the core's load/store units and fetch path and is the synthesizable replacement for the simulation RAM.

---
 rtl/ram_dual_be.sv | 162 ++++++++++++++++
 tb/tb_ram_dual_be.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ram_dual_be.sv
// ram_dual_be: dual-port, byte-masked, clock-enabled synchronous RAM.
// The array is zeroed by an internal sequencer after reset or on an AClr request.
// Port A wins byte collisions. The read latency (1 or 2) and the same-port
// read-during-write behaviour are selected by parameters.
module ram_dual_be #(
  parameter int CAddrLen = 13,
  parameter int CDataLen = 128,
  parameter int CRdLat   = 1,
  parameter int CWrFirst = 0
) (
  input  logic                    AClkH,
  input  logic                    AResetH,
  input  logic                    AClkHEn,
  input  logic                    AClr,
  output logic                    AReady,
  input  logic [CAddrLen-1:0]     AAddrA,
  input  logic [CAddrLen-1:0]     AAddrB,
  input  logic [CDataLen-1:0]     AMosiA,
  input  logic [CDataLen-1:0]     AMosiB,
  input  logic [CDataLen/8-1:0]   AWrEnA,
  input  logic [CDataLen/8-1:0]   AWrEnB,
  input  logic                    ARdEnA,
  input  logic                    ARdEnB,
  output logic [CDataLen-1:0]     AMisoA,
  output logic [CDataLen-1:0]     AMisoB
);

  localparam int CMaskLen  = CDataLen / 8;
  localparam int CNumWords = 2 ** CAddrLen;

  typedef enum logic {SInit, SRun} state_t;

  state_t                state_q;
  logic [CAddrLen-1:0]   cnt_q;
  logic                  ready_q;
  logic [CDataLen-1:0]   mem [CNumWords];

  logic                  acc;
  logic                  rd_a_acc, rd_b_acc;
  logic [CDataLen-1:0]   rdat_a_d, rdat_b_d;
  logic [CDataLen-1:0]   rdat_a_q, rdat_b_q;
  logic                  vld_a_q, vld_b_q;

  // Overlay the enabled bytes of a write word onto the stored word.
  function automatic logic [CDataLen-1:0] merge_bytes(
    input logic [CDataLen-1:0] old_w,
    input logic [CDataLen-1:0] new_w,
    input logic [CMaskLen-1:0] mask
  );
    logic [CDataLen-1:0] res;
    res = old_w;
    for (int i = 0; i < CMaskLen; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Requests count only on an enabled edge in Run without a concurrent clear.
  assign acc      = AClkHEn & ready_q & ~AClr;
  assign rd_a_acc = acc & ARdEnA;
  assign rd_b_acc = acc & ARdEnB;
  assign AReady   = ready_q;

  // Init/Run sequencer: zero every word once, then accept requests until AClr.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      state_q <= SInit;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (AClkHEn) begin
      case (state_q)
        SInit: begin
          if (cnt_q == '1) begin
            state_q <= SRun;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SRun: begin
          if (AClr) begin
            state_q <= SInit;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= SInit;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Array writes: the clear sequencer in Init, byte-masked port writes in Run.
  // Port A is assigned last so it owns any byte both ports enable.
  always_ff @(posedge AClkH) begin
    if (AClkHEn) begin
      if (state_q == SInit) begin
        mem[cnt_q] <= '0;
      end else if (acc) begin
        for (int i = 0; i < CMaskLen; i++) begin
          if (AWrEnB[i]) mem[AAddrB][8*i +: 8] <= AMosiB[8*i +: 8];
          if (AWrEnA[i]) mem[AAddrA][8*i +: 8] <= AMosiA[8*i +: 8];
        end
      end
    end
  end

  // Read word selection: old array contents, or own-port write data when write-first.
  always_comb begin
    rdat_a_d = mem[AAddrA];
    rdat_b_d = mem[AAddrB];
    if (CWrFirst != 0) begin
      rdat_a_d = merge_bytes(mem[AAddrA], AMosiA, AWrEnA);
      rdat_b_d = merge_bytes(mem[AAddrB], AMosiB, AWrEnB);
    end
  end

  // First read stage: capture the word at the sampling edge, zero for idle slots.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      vld_a_q  <= 1'b0;
      vld_b_q  <= 1'b0;
      rdat_a_q <= '0;
      rdat_b_q <= '0;
    end else if (AClkHEn) begin
      vld_a_q  <= rd_a_acc;
      vld_b_q  <= rd_b_acc;
      rdat_a_q <= rd_a_acc ? rdat_a_d : '0;
      rdat_b_q <= rd_b_acc ? rdat_b_d : '0;
    end
  end

  if (CRdLat == 2) begin : g_lat2
    logic [CDataLen-1:0] out_a_q, out_b_q;
    logic                vld2_a_q, vld2_b_q;

    // Second read stage: one extra enabled cycle of latency.
    always_ff @(posedge AClkH or posedge AResetH) begin
      if (AResetH) begin
        vld2_a_q <= 1'b0;
        vld2_b_q <= 1'b0;
        out_a_q  <= '0;
        out_b_q  <= '0;
      end else if (AClkHEn) begin
        vld2_a_q <= vld_a_q;
        vld2_b_q <= vld_b_q;
        out_a_q  <= vld_a_q ? rdat_a_q : '0;
        out_b_q  <= vld_b_q ? rdat_b_q : '0;
      end
    end

    assign AMisoA = vld2_a_q ? out_a_q : '0;
    assign AMisoB = vld2_b_q ? out_b_q : '0;
  end else begin : g_lat1
    assign AMisoA = vld_a_q ? rdat_a_q : '0;
    assign AMisoB = vld_b_q ? rdat_b_q : '0;
  end

endmodule

// File: tb/tb_ram_dual_be.sv
// Directed bench for ram_dual_be: two instances share the stimulus,
// dut0 is latency 1 / read-first, dut1 is latency 2 / write-first.
module tb_ram_dual_be;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic [3:0]  addr_a, addr_b;
  logic [31:0] mosi_a, mosi_b;
  logic [3:0]  wen_a, wen_b;
  logic        rd_a, rd_b;
  logic        ready0, ready1;
  logic [31:0] miso_a0, miso_b0, miso_a1, miso_b1;

  int n_checks;
  int n_errors;
  int cnt;

  ram_dual_be #(.CAddrLen(4), .CDataLen(32), .CRdLat(1), .CWrFirst(0)) dut0 (
    .AClkH(clk), .AResetH(rst), .AClkHEn(en), .AClr(clr), .AReady(ready0),
    .AAddrA(addr_a), .AAddrB(addr_b), .AMosiA(mosi_a), .AMosiB(mosi_b),
    .AWrEnA(wen_a), .AWrEnB(wen_b), .ARdEnA(rd_a), .ARdEnB(rd_b),
    .AMisoA(miso_a0), .AMisoB(miso_b0)
  );

  ram_dual_be #(.CAddrLen(4), .CDataLen(32), .CRdLat(2), .CWrFirst(1)) dut1 (
    .AClkH(clk), .AResetH(rst), .AClkHEn(en), .AClr(clr), .AReady(ready1),
    .AAddrA(addr_a), .AAddrB(addr_b), .AMosiA(mosi_a), .AMosiB(mosi_b),
    .AWrEnA(wen_a), .AWrEnB(wen_b), .ARdEnA(rd_a), .ARdEnB(rd_b),
    .AMisoA(miso_a1), .AMisoB(miso_b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; rd_a = 1'b0; rd_b = 1'b0; wen_a = '0; wen_b = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; en = 1'b1;
    addr_a = '0; addr_b = '0; mosi_a = '0; mosi_b = '0;
    idle();
    repeat (3) cyc();
    chk("rst_ready0", 32'(ready0), 32'd0);
    chk("rst_ready1", 32'(ready1), 32'd0);
    chk("rst_miso0", miso_a0, 32'h0);
    chk("rst_miso1", miso_b1, 32'h0);

    // Init length, with two disabled cycles that must not count.
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60 && !ready0; i++) begin
      en = (i == 4 || i == 5) ? 1'b0 : 1'b1;
      cyc();
      if (en) cnt++;
    end
    en = 1'b1;
    chk("init_len", 32'(cnt), 32'd16);
    chk("init_ready1", 32'(ready1), 32'd1);

    addr_a = 4'd7; rd_a = 1'b1; cyc();
    chk("init_rd7_l1", miso_a0, 32'h0);
    rd_a = 1'b0; cyc();
    chk("init_rd7_l2", miso_a1, 32'h0);

    // Byte-masked write over a prior value.
    addr_a = 4'd3; mosi_a = 32'h11223344; wen_a = 4'hF; cyc();
    mosi_a = 32'hAABBCCDD; wen_a = 4'b0101; cyc();
    wen_a = '0; rd_a = 1'b1; cyc();
    chk("mask_l1", miso_a0, 32'h11BB33DD);
    rd_a = 1'b0; cyc();
    chk("mask_l2", miso_a1, 32'h11BB33DD);
    chk("mask_l1_idle", miso_a0, 32'h0);
    addr_b = 4'd3; rd_b = 1'b1; cyc();
    chk("mask_portb", miso_b0, 32'h11BB33DD);
    rd_b = 1'b0;

    // Same-address byte collision, port A wins the shared byte.
    addr_a = 4'd5; mosi_a = 32'h11111111; wen_a = 4'b0011;
    addr_b = 4'd5; mosi_b = 32'h22222222; wen_b = 4'b0110;
    cyc();
    idle(); rd_b = 1'b1; cyc();
    chk("collide_l1", miso_b0, 32'h00221111);
    rd_b = 1'b0; cyc();
    chk("collide_l2", miso_b1, 32'h00221111);

    // Read during write, same and cross port.
    addr_a = 4'd2; mosi_a = 32'h5; wen_a = 4'hF; cyc();
    mosi_a = 32'h9; rd_a = 1'b1; addr_b = 4'd2; rd_b = 1'b1; cyc();
    chk("rdw_readfirst", miso_a0, 32'h5);
    chk("rdw_cross0", miso_b0, 32'h5);
    idle(); cyc();
    chk("rdw_writefirst", miso_a1, 32'h9);
    chk("rdw_cross1", miso_b1, 32'h5);
    cyc();
    chk("idle_zero", miso_a1, 32'h0);

    // Latency 2 across three disabled cycles; a write while disabled is ignored.
    addr_a = 4'd2; rd_a = 1'b1; cyc();
    chk("lat_l1", miso_a0, 32'h9);
    chk("lat_l2_early", miso_a1, 32'h0);
    rd_a = 1'b0; en = 1'b0; addr_a = 4'd4; mosi_a = 32'h77; wen_a = 4'hF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("lat_hold_l1", miso_a0, 32'h9);
      chk("lat_hold_l2", miso_a1, 32'h0);
    end
    en = 1'b1; wen_a = '0; cyc();
    chk("lat_l2", miso_a1, 32'h9);
    chk("lat_l1_done", miso_a0, 32'h0);
    cyc();
    chk("lat_l2_done", miso_a1, 32'h0);
    rd_a = 1'b1; cyc();
    chk("en_nowrite", miso_a0, 32'h0);
    rd_a = 1'b0;

    // AClr: in-flight read completes, concurrent write dropped, array re-cleared.
    addr_a = 4'd9; mosi_a = 32'hDEAD; wen_a = 4'hF; cyc();
    wen_a = '0; rd_a = 1'b1; cyc();
    chk("clr_rd_l1", miso_a0, 32'hDEAD);
    rd_a = 1'b0; clr = 1'b1; mosi_a = 32'hBEEF; wen_a = 4'hF; cyc();
    chk("clr_rd_l2", miso_a1, 32'hDEAD);
    chk("clr_ready", 32'(ready0), 32'd0);
    idle();
    cnt = 0;
    for (int i = 0; i < 60 && !ready0; i++) begin
      cyc();
      cnt++;
    end
    chk("clr_len", 32'(cnt), 32'd16);
    rd_a = 1'b1; cyc();
    chk("clr_rd9_l1", miso_a0, 32'h0);
    rd_a = 1'b0; cyc();
    chk("clr_rd9_l2", miso_a1, 32'h0);

    // Asynchronous reset while running.
    addr_a = 4'd1; mosi_a = 32'hCAFEF00D; wen_a = 4'hF; cyc();
    wen_a = '0; rd_a = 1'b1; cyc();
    chk("pre_rst_rd", miso_a0, 32'hCAFEF00D);
    rd_a = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_miso", miso_a0, 32'h0);
    chk("async_rst_ready", 32'(ready0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
